// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM burst arbiter: FSM state, slot width and slot-type decode.
package sdram_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int DEF_NUM_WR = 2;
   localparam int DEF_NUM_RD = 2;
   localparam int SLOT_W     = $clog2(DEF_NUM_WR + DEF_NUM_RD);

   // Writers occupy slots 0..num_wr-1; every slot at or above num_wr is a reader.
   function automatic logic is_rd(input int slot, input int num_wr);
      return slot >= num_wr;
   endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr, wrapping at N.
module sdram_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   // Scan from the farthest slot back to ptr so the nearest requester is written last and wins.
   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise unassigned paths infer latches.
      valid = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[PW'((int'(ptr) + k) % N)]) begin
            valid = 1'b1;
            idx   = PW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter sharing one sdram_core burst port among write and read masters.
// Optional build macro SDRAM_ARB_RD_PRIO_EN: pending readers always win over writers.
import sdram_arb_pkg::*;

module sdram_burst_arbiter #(
   parameter int NUM_WR     = DEF_NUM_WR,
   parameter int NUM_RD     = DEF_NUM_RD,
   parameter int DATA_BITS  = 16,
   parameter int ADDR_BITS  = 24,
   parameter int BURST_BITS = 10
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_WR-1:0]              m_wr_burst_req,
   input  logic [NUM_WR*BURST_BITS-1:0]   m_wr_burst_len,
   input  logic [NUM_WR*ADDR_BITS-1:0]    m_wr_burst_addr,
   input  logic [NUM_WR*DATA_BITS-1:0]    m_wr_burst_data,
   output logic [NUM_WR-1:0]              m_wr_burst_data_req,
   output logic [NUM_WR-1:0]              m_wr_burst_finish,
   input  logic [NUM_RD-1:0]              m_rd_burst_req,
   input  logic [NUM_RD*BURST_BITS-1:0]   m_rd_burst_len,
   input  logic [NUM_RD*ADDR_BITS-1:0]    m_rd_burst_addr,
   output logic [NUM_RD-1:0]              m_rd_burst_data_valid,
   output logic [DATA_BITS-1:0]           m_rd_burst_data,
   output logic [NUM_RD-1:0]              m_rd_burst_finish,
   output logic                           s_wr_burst_req,
   output logic [BURST_BITS-1:0]          s_wr_burst_len,
   output logic [ADDR_BITS-1:0]           s_wr_burst_addr,
   output logic [DATA_BITS-1:0]           s_wr_burst_data,
   input  logic                           s_wr_burst_data_req,
   input  logic                           s_wr_burst_finish,
   output logic                           s_rd_burst_req,
   output logic [BURST_BITS-1:0]          s_rd_burst_len,
   output logic [ADDR_BITS-1:0]           s_rd_burst_addr,
   input  logic                           s_rd_burst_data_valid,
   input  logic [DATA_BITS-1:0]           s_rd_burst_data,
   input  logic                           s_rd_burst_finish
);

   localparam int NSLOT = NUM_WR + NUM_RD;
   localparam int SW    = $clog2(NSLOT);

   state_t                state, state_nx;
   logic [SW-1:0]         gnt, rr_ptr, ptr_nx;
   logic [BURST_BITS-1:0] len_q, pick_len;
   logic [ADDR_BITS-1:0]  addr_q, pick_addr;
   logic                  pick_valid, grant_load, ptr_load, zero_fin;
   logic [SW-1:0]         pick_idx;
   logic                  gnt_rd, busy_wr, busy_rd, core_finish;

   function automatic logic [SW-1:0] inc_slot(input logic [SW-1:0] s);
      return (s == SW'(NSLOT - 1)) ? '0 : s + 1'b1;
   endfunction

`ifdef SDRAM_ARB_RD_PRIO_EN
   localparam int RW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int WW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   logic          rd_valid, wr_valid;
   logic [RW-1:0] rd_idx, rd_ptr;
   logic [WW-1:0] wr_idx, wr_ptr;

   // A pointer parked in the other group restarts that group's search at its first slot.
   assign rd_ptr = (rr_ptr >= SW'(NUM_WR)) ? RW'(rr_ptr - SW'(NUM_WR)) : '0;
   assign wr_ptr = (rr_ptr <  SW'(NUM_WR)) ? WW'(rr_ptr) : '0;

   sdram_rr_pick #(.N(NUM_RD), .PW(RW)) u_pick_rd (
      .req(m_rd_burst_req), .ptr(rd_ptr), .valid(rd_valid), .idx(rd_idx)
   );
   sdram_rr_pick #(.N(NUM_WR), .PW(WW)) u_pick_wr (
      .req(m_wr_burst_req), .ptr(wr_ptr), .valid(wr_valid), .idx(wr_idx)
   );

   assign pick_valid = rd_valid | wr_valid;
   assign pick_idx   = rd_valid ? SW'(NUM_WR) + SW'(rd_idx) : SW'(wr_idx);
`else
   sdram_rr_pick #(.N(NSLOT), .PW(SW)) u_pick (
      .req({m_rd_burst_req, m_wr_burst_req}), .ptr(rr_ptr), .valid(pick_valid), .idx(pick_idx)
   );
`endif

   always_comb begin
      pick_len  = '0;
      pick_addr = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (pick_idx == SW'(i)) begin
            pick_len  = m_wr_burst_len[i*BURST_BITS +: BURST_BITS];
            pick_addr = m_wr_burst_addr[i*ADDR_BITS +: ADDR_BITS];
         end
      end
      for (int i = 0; i < NUM_RD; i++) begin
         if (pick_idx == SW'(NUM_WR + i)) begin
            pick_len  = m_rd_burst_len[i*BURST_BITS +: BURST_BITS];
            pick_addr = m_rd_burst_addr[i*ADDR_BITS +: ADDR_BITS];
         end
      end
   end

   assign gnt_rd      = is_rd(int'(gnt), NUM_WR);
   assign busy_wr     = (state == BUSY) && !gnt_rd;
   assign busy_rd     = (state == BUSY) && gnt_rd;
   assign core_finish = gnt_rd ? s_rd_burst_finish : s_wr_burst_finish;

   always_comb begin
      state_nx   = state;
      grant_load = 1'b0;
      ptr_load   = 1'b0;
      ptr_nx     = rr_ptr;
      zero_fin   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               ptr_load = 1'b1;
               ptr_nx   = inc_slot(pick_idx);
               // Zero-length bursts never reach the core; the master is released immediately.
               if (pick_len == '0) begin
                  zero_fin = 1'b1;
               end else begin
                  grant_load = 1'b1;
                  state_nx   = BUSY;
               end
            end
         end
         BUSY: begin
            if (core_finish) begin
               ptr_load = 1'b1;
               ptr_nx   = inc_slot(gnt);
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt    <= '0;
         rr_ptr <= '0;
         len_q  <= '0;
         addr_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
         state <= state_nx;
         if (ptr_load) rr_ptr <= ptr_nx;
         if (grant_load) begin
            gnt    <= pick_idx;
            len_q  <= pick_len;
            addr_q <= pick_addr;
         end
      end
   end

   assign s_wr_burst_req  = busy_wr;
   assign s_wr_burst_len  = busy_wr ? len_q  : '0;
   assign s_wr_burst_addr = busy_wr ? addr_q : '0;
   assign s_rd_burst_req  = busy_rd;
   assign s_rd_burst_len  = busy_rd ? len_q  : '0;
   assign s_rd_burst_addr = busy_rd ? addr_q : '0;
   assign m_rd_burst_data = busy_rd ? s_rd_burst_data : '0;

   always_comb begin
      m_wr_burst_data_req   = '0;
      m_wr_burst_finish     = '0;
      m_rd_burst_data_valid = '0;
      m_rd_burst_finish     = '0;
      s_wr_burst_data       = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (busy_wr && gnt == SW'(i)) begin
            m_wr_burst_data_req[i] = s_wr_burst_data_req;
            m_wr_burst_finish[i]   = s_wr_burst_finish;
            s_wr_burst_data        = m_wr_burst_data[i*DATA_BITS +: DATA_BITS];
         end
         if (zero_fin && pick_idx == SW'(i)) m_wr_burst_finish[i] = 1'b1;
      end
      for (int i = 0; i < NUM_RD; i++) begin
         if (busy_rd && gnt == SW'(NUM_WR + i)) begin
            m_rd_burst_data_valid[i] = s_rd_burst_data_valid;
            m_rd_burst_finish[i]     = s_rd_burst_finish;
         end
         if (zero_fin && pick_idx == SW'(NUM_WR + i)) m_rd_burst_finish[i] = 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed self-checking bench for sdram_burst_arbiter (default build and SDRAM_ARB_RD_PRIO_EN build).
module tb_sdram_burst_arbiter;

   localparam int NUM_WR = 2, NUM_RD = 2, DATA_BITS = 16, ADDR_BITS = 24, BURST_BITS = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NUM_WR-1:0]            m_wr_burst_req = '0;
   logic [NUM_WR*BURST_BITS-1:0] m_wr_burst_len = '0;
   logic [NUM_WR*ADDR_BITS-1:0]  m_wr_burst_addr = '0;
   logic [NUM_WR*DATA_BITS-1:0]  m_wr_burst_data = '0;
   logic [NUM_WR-1:0]            m_wr_burst_data_req, m_wr_burst_finish;
   logic [NUM_RD-1:0]            m_rd_burst_req = '0;
   logic [NUM_RD*BURST_BITS-1:0] m_rd_burst_len = '0;
   logic [NUM_RD*ADDR_BITS-1:0]  m_rd_burst_addr = '0;
   logic [NUM_RD-1:0]            m_rd_burst_data_valid, m_rd_burst_finish;
   logic [DATA_BITS-1:0]         m_rd_burst_data;
   logic                         s_wr_burst_req, s_rd_burst_req;
   logic [BURST_BITS-1:0]        s_wr_burst_len, s_rd_burst_len;
   logic [ADDR_BITS-1:0]         s_wr_burst_addr, s_rd_burst_addr;
   logic [DATA_BITS-1:0]         s_wr_burst_data;
   logic                         s_wr_burst_data_req = 1'b0, s_wr_burst_finish = 1'b0;
   logic                         s_rd_burst_data_valid = 1'b0, s_rd_burst_finish = 1'b0;
   logic [DATA_BITS-1:0]         s_rd_burst_data = '0;

   int errors = 0;
   int checks = 0;

   sdram_burst_arbiter #(
      .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .DATA_BITS(DATA_BITS),
      .ADDR_BITS(ADDR_BITS), .BURST_BITS(BURST_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_wr_burst_req(m_wr_burst_req), .m_wr_burst_len(m_wr_burst_len),
      .m_wr_burst_addr(m_wr_burst_addr), .m_wr_burst_data(m_wr_burst_data),
      .m_wr_burst_data_req(m_wr_burst_data_req), .m_wr_burst_finish(m_wr_burst_finish),
      .m_rd_burst_req(m_rd_burst_req), .m_rd_burst_len(m_rd_burst_len),
      .m_rd_burst_addr(m_rd_burst_addr), .m_rd_burst_data_valid(m_rd_burst_data_valid),
      .m_rd_burst_data(m_rd_burst_data), .m_rd_burst_finish(m_rd_burst_finish),
      .s_wr_burst_req(s_wr_burst_req), .s_wr_burst_len(s_wr_burst_len),
      .s_wr_burst_addr(s_wr_burst_addr), .s_wr_burst_data(s_wr_burst_data),
      .s_wr_burst_data_req(s_wr_burst_data_req), .s_wr_burst_finish(s_wr_burst_finish),
      .s_rd_burst_req(s_rd_burst_req), .s_rd_burst_len(s_rd_burst_len),
      .s_rd_burst_addr(s_rd_burst_addr), .s_rd_burst_data_valid(s_rd_burst_data_valid),
      .s_rd_burst_data(s_rd_burst_data), .s_rd_burst_finish(s_rd_burst_finish)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not terminate");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive and sample points sit 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Plays the core for one burst: waits for a request, gives one beat, then pulses finish.
   task automatic serve(output int slot, output int idle);
      logic [1:0] v, f;
      logic       is_wr;
      idle = 0;
      slot = -1;
      while (!(s_wr_burst_req || s_rd_burst_req) && idle < 20) begin
         tick();
         idle++;
      end
      check("grant_timeout", 32'(s_wr_burst_req | s_rd_burst_req), 32'd1);
      is_wr = s_wr_burst_req;
      if (is_wr) s_wr_burst_data_req = 1'b1;
      else       s_rd_burst_data_valid = 1'b1;
      #1 v = is_wr ? m_wr_burst_data_req : m_rd_burst_data_valid;
      tick();
      s_wr_burst_data_req   = 1'b0;
      s_rd_burst_data_valid = 1'b0;
      if (is_wr) s_wr_burst_finish = 1'b1;
      else       s_rd_burst_finish = 1'b1;
      #1 f = is_wr ? m_wr_burst_finish : m_rd_burst_finish;
      check("finish_routed", 32'(f), 32'(v));
      tick();
      s_wr_burst_finish = 1'b0;
      s_rd_burst_finish = 1'b0;
      slot = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : -1;
      if (!is_wr && slot >= 0) slot += NUM_WR;
   endtask

   initial begin
      int beats, stray, slot, idle, seen;
`ifdef SDRAM_ARB_RD_PRIO_EN
      int exp_order[5] = '{2, 3, 2, 3, 0};
`else
      int exp_order[5] = '{0, 1, 2, 3, 0};
`endif

      // Power-on reset
      repeat (3) tick();
      check("rst_s_wr_req", 32'(s_wr_burst_req), 32'd0);
      check("rst_s_rd_req", 32'(s_rd_burst_req), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single writer, len=256, addr=0
      m_wr_burst_len  = {10'd0, 10'd256};
      m_wr_burst_addr = {24'h0, 24'h0};
      m_wr_burst_data = {16'h0000, 16'h1234};
      m_wr_burst_req  = 2'b01;
      #1 check("wr_req_not_yet", 32'(s_wr_burst_req), 32'd0);
      tick();
      #1;
      check("wr_req_rise", 32'(s_wr_burst_req), 32'd1);
      check("wr_len", 32'(s_wr_burst_len), 32'd256);
      check("wr_addr", 32'(s_wr_burst_addr), 32'd0);
      check("wr_data_mux", 32'(s_wr_burst_data), 32'h1234);
      check("rd_req_idle", 32'(s_rd_burst_req), 32'd0);
      beats = 0;
      stray = 0;
      s_wr_burst_data_req = 1'b1;
      repeat (256) begin
         #1;
         if (m_wr_burst_data_req == 2'b01) beats++;
         else stray++;
         tick();
      end
      s_wr_burst_data_req = 1'b0;
      check("wr_beats", 32'(beats), 32'd256);
      check("wr_stray_beats", 32'(stray), 32'd0);
      s_wr_burst_finish = 1'b1;
      #1 check("wr_finish_pulse", 32'(m_wr_burst_finish), 32'h1);
      tick();
      s_wr_burst_finish = 1'b0;
      m_wr_burst_req    = 2'b00;
      #1;
      check("wr_finish_once", 32'(m_wr_burst_finish), 32'h0);
      check("wr_req_drop", 32'(s_wr_burst_req), 32'd0);

      // Reset mid-burst: writer 1 granted, then rst_n asserted between edges
      m_wr_burst_len  = {10'd8, 10'd8};
      m_wr_burst_addr = {24'h000200, 24'h000100};
      m_wr_burst_data = {16'hBBBB, 16'hAAAA};
      m_rd_burst_len  = {10'd8, 10'd8};
      m_rd_burst_addr = {24'h000400, 24'h000300};
      m_wr_burst_req  = 2'b10;
      tick();
      #1 check("mid_wr_req", 32'(s_wr_burst_req), 32'd1);
      s_wr_burst_data_req = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_s_wr_req", 32'(s_wr_burst_req), 32'd0);
      check("arst_s_wr_addr", 32'(s_wr_burst_addr), 32'd0);
      check("arst_m_data_req", 32'(m_wr_burst_data_req), 32'd0);
      check("arst_s_wr_data", 32'(s_wr_burst_data), 32'd0);
      s_wr_burst_data_req = 1'b0;
      m_wr_burst_req = 2'b11;
      m_rd_burst_req = 2'b11;
      tick();
      tick();
      rst_n = 1'b1;

      // All masters requesting continuously; first grant proves rr_ptr restarted at 0
      for (int i = 0; i < 5; i++) begin
`ifdef SDRAM_ARB_RD_PRIO_EN
         if (i == 4) m_rd_burst_req = 2'b00;
`endif
         serve(slot, idle);
         check($sformatf("rr_order_%0d", i), 32'(slot), 32'(exp_order[i]));
         check($sformatf("rr_idle_%0d", i), 32'(idle), 32'd1);
      end
      m_wr_burst_req = 2'b00;
      m_rd_burst_req = 2'b00;
      tick();

      // Reader 1 with len=0 is finished locally and never forwarded
      m_rd_burst_len = {10'd0, 10'd8};
      m_rd_burst_req = 2'b10;
      #1 check("zero_len_finish", 32'(m_rd_burst_finish), 32'h2);
      seen = int'(s_rd_burst_req);
      tick();
      m_rd_burst_req = 2'b00;
      repeat (3) begin
         #1 seen += int'(s_rd_burst_req);
         tick();
      end
      check("zero_len_no_fwd", 32'(seen), 32'd0);
      check("zero_len_fin_off", 32'(m_rd_burst_finish), 32'h0);

      // Reader 0 granted; reader 1 waits; reader 0 drops its request mid-burst
      m_rd_burst_len = {10'd4, 10'd4};
      m_rd_burst_req = 2'b11;
      tick();
      #1;
      check("rd0_req", 32'(s_rd_burst_req), 32'd1);
      check("rd0_addr", 32'(s_rd_burst_addr), 32'h000300);
      check("rd0_len", 32'(s_rd_burst_len), 32'd4);
      s_rd_burst_data = 16'hA5A5;
      s_rd_burst_data_valid = 1'b1;
      #1;
      check("rd0_valid_route", 32'(m_rd_burst_data_valid), 32'h1);
      check("rd_data_bcast", 32'(m_rd_burst_data), 32'hA5A5);
      tick();
      m_rd_burst_req = 2'b10;
      #1;
      check("rd0_drop_ignored", 32'(s_rd_burst_req), 32'd1);
      check("rd0_valid_hold", 32'(m_rd_burst_data_valid), 32'h1);
      s_rd_burst_data_valid = 1'b0;
      s_rd_burst_finish = 1'b1;
      #1 check("rd0_finish", 32'(m_rd_burst_finish), 32'h1);
      tick();
      s_rd_burst_finish = 1'b0;
      #1 check("rd_gap_idle", 32'(s_rd_burst_req), 32'd0);
      tick();
      #1;
      check("rd1_pending_grant", 32'(s_rd_burst_req), 32'd1);
      check("rd1_addr", 32'(s_rd_burst_addr), 32'h000400);
      s_rd_burst_data_valid = 1'b1;
      #1 check("rd1_valid_route", 32'(m_rd_burst_data_valid), 32'h2);
      tick();
      s_rd_burst_data_valid = 1'b0;
      s_rd_burst_finish = 1'b1;
      #1 check("rd1_finish", 32'(m_rd_burst_finish), 32'h2);
      tick();
      s_rd_burst_finish = 1'b0;
      m_rd_burst_req = 2'b00;
      tick();

      // Finish from the core while idle is ignored
      s_wr_burst_finish = 1'b1;
      s_rd_burst_finish = 1'b1;
      #1;
      check("idle_wr_finish", 32'(m_wr_burst_finish), 32'h0);
      check("idle_rd_finish", 32'(m_rd_burst_finish), 32'h0);
      tick();
      s_wr_burst_finish = 1'b0;
      s_rd_burst_finish = 1'b0;
      tick();
      #1 check("idle_no_req", 32'(s_wr_burst_req | s_rd_burst_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
